// File: rtl/ssd_scan_monitor.sv
// ssd_scan_monitor
//   Receive-side monitor for a 4-digit multiplexed seven-segment bus. It
//   synchronizes the scanned anode/segment bus and qualifies each scan slot
//   for stability. It decodes the active-low glyph back to a hex value and
//   rebuilds per-digit value, valid and lit (mode) state.
//
// Ports
//   stateClk    sampling clock, rising edge
//   rst         asynchronous reset, active high
//   an[3:0]     anode bus, active low; an[i]=0 selects digit i
//   seg[6:0]    segment bus {g,f,e,d,c,b,a}, active low
//   digit0..3   last decoded hex value per digit
//   valid[3:0]  digit's last capture was a legal hex glyph
//   mode[3:0]   digit's last capture had at least one segment lit
//   update      one-cycle pulse on every capture
//   error       one-cycle pulse on entry into a multiple-anode-low condition
//
// Optional build macro SSD_SCAN_MONITOR_FRAME_EN adds:
//   frame_done       one-cycle pulse when all four digits have been captured
//   frame_count[7:0] wrapping count of completed frames
//
// FSM states
//   state | meaning
//   IDLE  | no legal slot on the bus (all anodes high or several low)
//   QUAL  | legal slot held in snapshot, counting identical samples
//   HOLD  | slot captured, waiting for the bus to change

module ssd_scan_monitor #(
    parameter int STABLE_COUNT  = 4,
    parameter int TIMEOUT_COUNT = 64
) (
    input  logic       stateClk,
    input  logic       rst,
    input  logic [3:0] an,
    input  logic [6:0] seg,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] valid,
    output logic [3:0] mode,
    output logic       update,
    output logic       error
`ifdef SSD_SCAN_MONITOR_FRAME_EN
    ,
    output logic       frame_done,
    output logic [7:0] frame_count
`endif
);

    localparam int CNT_MAX = (STABLE_COUNT > TIMEOUT_COUNT) ? STABLE_COUNT : TIMEOUT_COUNT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] STABLE_LIM = CW'(STABLE_COUNT);
    localparam logic [CW-1:0] TIME_LIM   = CW'(TIMEOUT_COUNT);

    typedef enum logic [1:0] {IDLE, QUAL, HOLD} state_t;

    state_t        state;
    logic [3:0]    an_s1, an_s2;
    logic [6:0]    seg_s1, seg_s2;
    logic [10:0]   sample;
    logic [10:0]   snap;
    logic [1:0]    snap_idx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [CW-1:0] tcnt [4];
    logic [3:0]    digit_q [4];
    logic          prev_multi;

    logic          slot_legal;
    logic          slot_multi;
    logic [1:0]    slot_idx;
    logic          same;
    logic          reeval;
    logic          cap_now;
    logic [4:0]    glyph;

    // Returns {legal, value} for an active-low {g..a} segment pattern.
    function automatic logic [4:0] decode_glyph(input logic [6:0] s);
        case (s)
            7'h40:   return 5'h10;
            7'h79:   return 5'h11;
            7'h24:   return 5'h12;
            7'h30:   return 5'h13;
            7'h19:   return 5'h14;
            7'h12:   return 5'h15;
            7'h02:   return 5'h16;
            7'h78:   return 5'h17;
            7'h00:   return 5'h18;
            7'h10:   return 5'h19;
            7'h08:   return 5'h1A;
            7'h03:   return 5'h1B;
            7'h46:   return 5'h1C;
            7'h21:   return 5'h1D;
            7'h06:   return 5'h1E;
            7'h0E:   return 5'h1F;
            default: return 5'h00;
        endcase
    endfunction

    // Two-flop synchronizers; reset to the idle bus so no slot appears.
    always_ff @(posedge stateClk or posedge rst) begin
        if (rst) begin
            an_s1  <= 4'hF;
            an_s2  <= 4'hF;
            seg_s1 <= 7'h7F;
            seg_s2 <= 7'h7F;
        end else begin
            an_s1  <= an;
            an_s2  <= an_s1;
            seg_s1 <= seg;
            seg_s2 <= seg_s1;
        end
    end

    assign sample = {an_s2, seg_s2};

    always_comb begin
        slot_legal = 1'b1;
        slot_idx   = 2'd0;
        case (an_s2)
            4'b1110: slot_idx = 2'd0;
            4'b1101: slot_idx = 2'd1;
            4'b1011: slot_idx = 2'd2;
            4'b0111: slot_idx = 2'd3;
            default: slot_legal = 1'b0;
        endcase
    end

    assign slot_multi = !slot_legal && (an_s2 != 4'hF);
    assign same       = (sample == snap);
    // Any sample that is not a repeat of the held slot is judged afresh.
    assign reeval     = (state == IDLE) || !same;
    assign cnt_inc    = cnt + CW'(1);
    assign cap_now    = (state == QUAL) && same && (cnt_inc == STABLE_LIM);
    assign glyph      = decode_glyph(snap[6:0]);

    always_ff @(posedge stateClk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            snap       <= 11'h7FF;
            snap_idx   <= 2'd0;
            cnt        <= '0;
            prev_multi <= 1'b0;
            update     <= 1'b0;
            error      <= 1'b0;
            valid      <= 4'h0;
            mode       <= 4'h0;
            for (int i = 0; i < 4; i++) begin
                tcnt[i]    <= '0;
                digit_q[i] <= 4'h0;
            end
        end else begin
            update     <= 1'b0;
            error      <= 1'b0;
            prev_multi <= slot_multi;

            if (reeval) begin
                if (slot_legal) begin
                    snap     <= sample;
                    snap_idx <= slot_idx;
                    cnt      <= CW'(1);
                    state    <= QUAL;
                end else begin
                    cnt   <= '0;
                    state <= IDLE;
                    error <= slot_multi && !prev_multi;
                end
            end else if (state == QUAL) begin
                cnt <= cnt_inc;
                if (cap_now) begin
                    state <= HOLD;
                end
            end

            for (int i = 0; i < 4; i++) begin
                if (cap_now && (snap_idx == i[1:0])) begin
                    tcnt[i] <= '0;
                end else if (tcnt[i] != TIME_LIM) begin
                    tcnt[i] <= tcnt[i] + CW'(1);
                    if (tcnt[i] + CW'(1) == TIME_LIM) begin
                        mode[i]  <= 1'b0;
                        valid[i] <= 1'b0;
                    end
                end
            end

            // Placed after the timeout loop so a coinciding capture wins.
            if (cap_now) begin
                update <= 1'b1;
                if (snap[6:0] == 7'h7F) begin
                    mode[snap_idx]  <= 1'b0;
                    valid[snap_idx] <= 1'b0;
                end else if (glyph[4]) begin
                    digit_q[snap_idx] <= glyph[3:0];
                    valid[snap_idx]   <= 1'b1;
                    mode[snap_idx]    <= 1'b1;
                end else begin
                    mode[snap_idx]  <= 1'b1;
                    valid[snap_idx] <= 1'b0;
                end
            end
        end
    end

    assign digit0 = digit_q[0];
    assign digit1 = digit_q[1];
    assign digit2 = digit_q[2];
    assign digit3 = digit_q[3];

`ifdef SSD_SCAN_MONITOR_FRAME_EN
    logic [3:0] seen;
    logic [3:0] seen_next;

    assign seen_next = seen | (cap_now ? (4'b0001 << snap_idx) : 4'b0000);

    always_ff @(posedge stateClk or posedge rst) begin
        if (rst) begin
            seen        <= 4'h0;
            frame_done  <= 1'b0;
            frame_count <= 8'h00;
        end else begin
            frame_done <= 1'b0;
            if (seen_next == 4'hF) begin
                frame_done  <= 1'b1;
                frame_count <= frame_count + 8'd1;
                seen        <= 4'h0;
            end else begin
                seen <= seen_next;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ssd_scan_monitor.sv
// Testbench for ssd_scan_monitor: table of scan slots with hand-computed
// results, hand-written multi-cycle sequences, and a randomized phase checked
// every cycle against a run-length based reference model.

module tb_ssd_scan_monitor;

    localparam int S = 4;
    localparam int T = 64;

    logic       stateClk = 1'b0;
    logic       rst      = 1'b1;
    logic [3:0] an       = 4'hF;
    logic [6:0] seg      = 7'h7F;
    logic [3:0] digit0, digit1, digit2, digit3;
    logic [3:0] valid, mode;
    logic       update, error;
`ifdef SSD_SCAN_MONITOR_FRAME_EN
    logic       frame_done;
    logic [7:0] frame_count;
`endif

    ssd_scan_monitor #(.STABLE_COUNT(S), .TIMEOUT_COUNT(T)) dut (
        .stateClk (stateClk),
        .rst      (rst),
        .an       (an),
        .seg      (seg),
        .digit0   (digit0),
        .digit1   (digit1),
        .digit2   (digit2),
        .digit3   (digit3),
        .valid    (valid),
        .mode     (mode),
        .update   (update),
        .error    (error)
`ifdef SSD_SCAN_MONITOR_FRAME_EN
        ,
        .frame_done  (frame_done),
        .frame_count (frame_count)
`endif
    );

    always #5 stateClk = ~stateClk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Glyph table written in abcdefg order, MSB = segment a, 0 = lit.
    logic [6:0] glyph_abc [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        logic [6:0] abc;
        logic [6:0] s;
        abc = glyph_abc[v];
        for (int j = 0; j < 7; j++) s[j] = abc[6-j];
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge stateClk);
        #1;
    endtask

    task automatic wait_update(output int e);
        e = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (update === 1'b1) begin
                e = k;
                break;
            end
        end
    endtask

    // ---------------- reference model ----------------
    // A slot is captured when the S-th consecutive identical synchronized
    // sample of a legal slot arrives; synchronized = input two edges back.
    logic [10:0] pipe0, pipe1, prev_smp;
    int          run;
    bit          prev_multi_m;
    int          cyc;
    int          last_cap [4];
    logic [3:0]  md [4];
    logic [3:0]  mv, mm;
    bit          mu, me;

    always @(posedge stateClk or posedge rst) begin
        logic [10:0] smp;
        int          zeros;
        int          idx;
        logic [6:0]  sg;
        int          val;
        if (rst) begin
            pipe0 = 11'h7FF; pipe1 = 11'h7FF; prev_smp = 11'h7FF;
            run = 0; prev_multi_m = 0; cyc = 0;
            mv = 4'h0; mm = 4'h0; mu = 0; me = 0;
            for (int i = 0; i < 4; i++) begin
                md[i] = 4'h0;
                last_cap[i] = 0;
            end
        end else begin
            cyc++;
            smp   = pipe1;
            pipe1 = pipe0;
            pipe0 = {an, seg};
            zeros = 0;
            idx   = 0;
            for (int j = 0; j < 4; j++) begin
                if (!smp[7+j]) begin
                    zeros++;
                    idx = j;
                end
            end
            if (smp == prev_smp) run = (run < 1000) ? run + 1 : run;
            else run = 1;
            mu = 0;
            me = (zeros > 1) && !prev_multi_m;
            for (int i = 0; i < 4; i++) begin
                if (cyc - last_cap[i] == T) begin
                    mv[i] = 1'b0;
                    mm[i] = 1'b0;
                end
            end
            if (zeros == 1 && run == S) begin
                mu = 1;
                last_cap[idx] = cyc;
                sg = smp[6:0];
                val = -1;
                for (int v = 0; v < 16; v++) if (seg_of(4'(v)) == sg) val = v;
                if (sg == 7'h7F) begin
                    mv[idx] = 1'b0; mm[idx] = 1'b0;
                end else if (val >= 0) begin
                    md[idx] = 4'(val); mv[idx] = 1'b1; mm[idx] = 1'b1;
                end else begin
                    mv[idx] = 1'b0; mm[idx] = 1'b1;
                end
            end
            prev_smp     = smp;
            prev_multi_m = (zeros > 1);
        end
    end

    always @(negedge stateClk) begin
        if (chk_en && !rst) begin
            n_vec++;
            if ({digit3, digit2, digit1, digit0, valid, mode, update, error} !==
                {md[3], md[2], md[1], md[0], mv, mm, mu, me}) begin
                n_err++;
                $display("FAIL model_cycle: got d=%h%h%h%h v=%b m=%b u=%b e=%b expected d=%h%h%h%h v=%b m=%b u=%b e=%b at %0t",
                         digit3, digit2, digit1, digit0, valid, mode, update, error,
                         md[3], md[2], md[1], md[0], mv, mm, mu, me, $time);
            end
        end
    end

    // ---------------- directed table ----------------
    typedef struct {
        logic [3:0]  an;
        logic [6:0]  seg;
        int          cycles;
        logic [15:0] digits;
        logic [3:0]  valid;
        logic [3:0]  mode;
    } vec_t;

    vec_t tbl [7];

    logic [3:0] multi_pat [8] = '{4'b1100, 4'b1010, 4'b0000, 4'b0110,
                                  4'b1001, 4'b0011, 4'b1000, 4'b0101};

    initial begin
        int e;
        int nu;
        int ne;
        int r;
        int hold;

        tbl[0] = '{4'b0111, seg_of(4'hA), 12, 16'hA001, 4'b1001, 4'b1001};
        tbl[1] = '{4'b1011, seg_of(4'h5), 12, 16'hA501, 4'b1101, 4'b1101};
        tbl[2] = '{4'b1101, seg_of(4'h0), 12, 16'hA501, 4'b1111, 4'b1111};
        tbl[3] = '{4'b1110, seg_of(4'hF), 12, 16'hA50F, 4'b1111, 4'b1111};
        tbl[4] = '{4'b1101, seg_of(4'h7),  8, 16'hA57F, 4'b1111, 4'b1111};
        tbl[5] = '{4'b1101, 7'h7F,         8, 16'hA57F, 4'b1101, 4'b1101};
        tbl[6] = '{4'b1111, 7'h7F,        10, 16'hA57F, 4'b0101, 4'b0101};

        // Reset state
        repeat (3) tick();
        chk("reset_outputs", 32'({digit3, digit2, digit1, digit0, valid, mode, update, error}), 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        // First capture latency
        an = 4'b1110; seg = seg_of(4'h1);
        wait_update(e);
        chk("latency_first", 32'(e), 32'd6);
        chk("first_digit0", 32'(digit0), 32'd1);
        chk("first_valid", 32'(valid), 32'b0001);
        chk("first_mode", 32'(mode), 32'b0001);

        // Table of slots
        for (int i = 0; i < 7; i++) begin
            an = tbl[i].an; seg = tbl[i].seg;
            repeat (tbl[i].cycles) tick();
            chk($sformatf("tbl%0d_digits", i), 32'({digit3, digit2, digit1, digit0}), 32'(tbl[i].digits));
            chk($sformatf("tbl%0d_valid", i), 32'(valid), 32'(tbl[i].valid));
            chk($sformatf("tbl%0d_mode", i), 32'(mode), 32'(tbl[i].mode));
        end

        // Segments toggling every 3 cycles: never stable long enough
        nu = 0; ne = 0;
        an = 4'b1110;
        for (int k = 0; k < 40; k++) begin
            if (k % 3 == 0) seg = ((k / 3) % 2 == 1) ? seg_of(4'h3) : seg_of(4'h8);
            tick();
            if (update === 1'b1) nu++;
            if (error === 1'b1) ne++;
        end
        chk("toggle_updates", 32'(nu), 32'd0);
        chk("toggle_digits", 32'({digit3, digit2, digit1, digit0}), 32'hA57F);
        chk("toggle_valid", 32'(valid), 32'b0000);

        // Two anodes low: one error pulse, no capture
        nu = 0; ne = 0;
        an = 4'b1100; seg = 7'h7F;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (update === 1'b1) nu++;
            if (error === 1'b1) ne++;
        end
        chk("multi_errors", 32'(ne), 32'd1);
        chk("multi_updates", 32'(nu), 32'd0);
        an = 4'b1110; seg = seg_of(4'h3);
        wait_update(e);
        chk("after_multi_latency", 32'(e), 32'd6);
        chk("after_multi_digit0", 32'(digit0), 32'd3);
        chk("after_multi_valid", 32'(valid), 32'b0001);
        chk("after_multi_mode", 32'(mode), 32'b0001);

        // Timeout of digit2 while only digit0 is scanned
        an = 4'b1011; seg = seg_of(4'h9);
        wait_update(e);
        chk("to_capture_latency", 32'(e), 32'd6);
        an = 4'b1110; seg = seg_of(4'h3);
        for (int a = 1; a <= 70; a++) begin
            tick();
            if (a == 63) chk("to_age63_vm2", 32'({valid[2], mode[2]}), 32'b11);
            if (a == 64) chk("to_age64_vm2", 32'({valid[2], mode[2]}), 32'b00);
        end
        chk("to_digit2_kept", 32'(digit2), 32'h9);

        // Reset while a slot is qualifying
        an = 4'b0111; seg = seg_of(4'hC);
        repeat (4) tick();
        rst = 1'b1;
        repeat (2) tick();
        chk("midreset_outputs", 32'({digit3, digit2, digit1, digit0, valid, mode, update, error}), 32'd0);
        rst = 1'b0;
        wait_update(e);
        chk("midreset_latency", 32'(e), 32'd6);
        chk("midreset_digits", 32'({digit3, digit2, digit1, digit0}), 32'hC000);
        chk("midreset_valid", 32'(valid), 32'b1000);

        // Randomized slots against the model
        for (int s = 0; s < 300; s++) begin
            r = $urandom_range(0, 9);
            if (r <= 5)      an = ~(4'b0001 << $urandom_range(0, 3));
            else if (r == 6) an = 4'hF;
            else             an = multi_pat[$urandom_range(0, 7)];
            r = $urandom_range(0, 9);
            if (r <= 6)      seg = seg_of(4'($urandom_range(0, 15)));
            else if (r == 7) seg = 7'h7F;
            else             seg = 7'($urandom_range(0, 127));
            hold = ($urandom_range(0, 19) == 0) ? $urandom_range(20, 80) : $urandom_range(1, 12);
            repeat (hold) tick();
            if (s == 150) begin
                rst = 1'b1;
                repeat (3) tick();
                rst = 1'b0;
            end
        end
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
